imm_packer: RTL and testbench

Immediate encoder and instruction-memory loader, the inverse of the datapath sign-extend stage. It accepts instruction header fields plus a full 32-bit immediate value, which is the value the extend stage must reproduce, over a valid/ready handshake. It range-checks the immediate against the selected ImmSrc format, packs the field into a 32-bit instruction word, and writes the word to instruction memory at an auto-incrementing address. It sits between the test/boot loader and the instruction memory write port.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_range_check.sv | 25 ++
 rtl/imm_packer.sv | 88 ++++++++
 tb/tb_imm_packer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants and FSM state type for the immediate packer and its
// range checker.
package imm_pkg;

  localparam logic IMM_SRC_DP = 1'b0;
  localparam logic IMM_SRC_BR = 1'b1;

  localparam int DP_IMM_W = 12;
  localparam int BR_IMM_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FULL
  } state_t;

endpackage

// File: rtl/imm_range_check.sv
// Decides whether a full 32-bit immediate is reproducible by the extend stage
// for the chosen format, and extracts the field that encodes it.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [31:0]         in_imm,
  input  logic                in_imm_src,
  output logic                legal,
  output logic [BR_IMM_W-1:0] field
);

  always_comb begin
    legal = 1'b0;
    field = '0;
    if (in_imm_src == IMM_SRC_DP) begin
      legal = (in_imm[31:DP_IMM_W] == '0);
      field = {{(BR_IMM_W - DP_IMM_W){1'b0}}, in_imm[DP_IMM_W-1:0]};
    end else if (in_imm_src == IMM_SRC_BR) begin
      // Word offset: two zero LSBs, and bits 31:25 must be copies of bit 25.
      legal = (in_imm[1:0] == 2'b00) && (in_imm[31:25] == {7{in_imm[25]}});
      field = in_imm[25:2];
    end
  end

endmodule

// File: rtl/imm_packer.sv
// Packs header + immediate into instruction words and streams them into
// instruction memory at an auto-incrementing word address.
module imm_packer
  import imm_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [19:0]       in_hdr,
  input  logic [31:0]       in_imm,
  input  logic              in_imm_src,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              done,
  output state_t            state
);

  logic [ADDR_W-1:0]   addr;
  logic                legal;
  logic [BR_IMM_W-1:0] field;
  logic                accept;
  logic                at_max;

  imm_range_check u_range_check (
    .in_imm     (in_imm),
    .in_imm_src (in_imm_src),
    .legal      (legal),
    .field      (field)
  );

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready.
  // in_valid must not depend on in_ready; in_ready is low whenever load_base
  // is high so a reload always wins over a beat in the same cycle.
  assign in_ready = (state == RUN) && !load_base;
  assign accept   = in_valid && in_ready;
  assign at_max   = (addr == {ADDR_W{1'b1}});
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      if (load_base) begin
        state <= RUN;
        addr  <= base_addr;
      end else if (accept) begin
        if (legal) begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= (in_imm_src == IMM_SRC_DP) ? {in_hdr, field[DP_IMM_W-1:0]}
                                                : {in_hdr[19:12], field};
          // Increment rolls over to 0 at the top, which is the wrap behaviour.
          addr    <= addr + ADDR_W'(1);
          if (at_max && !WRAP) begin
            state <= FULL;
          end
        end else begin
          err <= 1'b1;
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        if (in_last) begin
          state <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: a stopping (WRAP=0) and a wrapping (WRAP=1) instance
// with a 4-word memory share one stimulus stream.
module tb_imm_packer;
  import imm_pkg::*;

  localparam int W = 34;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;
  localparam int S_FULL = 3;

  logic        clk;
  logic        reset, load_base, in_valid, in_imm_src, in_last;
  logic [1:0]  base_addr;
  logic [19:0] in_hdr;
  logic [31:0] in_imm;

  logic        in_ready_o [2];
  logic        wr_en_o    [2];
  logic        err_o      [2];
  logic        done_o     [2];
  logic [1:0]  wr_addr_o  [2];
  logic [31:0] wr_data_o  [2];
  logic [7:0]  err_cnt_o  [2];
  state_t      state_o    [2];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per instance, a memory pointer, mode and reject count.
  int          m_st   [2];
  int          m_addr [2];
  int          m_errs [2];
  bit          exp_wr_en [2];
  bit          exp_err   [2];
  bit          exp_ready [2];
  bit          seen_ready[2];
  int          exp_addr  [2];
  logic [31:0] exp_data  [2];
  logic [W-1:0] exp_q[$];

  imm_packer #(.ADDR_W(2), .WRAP(1'b0)) u_stop (
    .clk(clk), .reset(reset), .load_base(load_base), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready_o[0]), .in_hdr(in_hdr), .in_imm(in_imm),
    .in_imm_src(in_imm_src), .in_last(in_last), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
    .wr_data(wr_data_o[0]), .err(err_o[0]), .err_cnt(err_cnt_o[0]), .done(done_o[0]),
    .state(state_o[0])
  );

  imm_packer #(.ADDR_W(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .load_base(load_base), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready_o[1]), .in_hdr(in_hdr), .in_imm(in_imm),
    .in_imm_src(in_imm_src), .in_last(in_last), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
    .wr_data(wr_data_o[1]), .err(err_o[1]), .err_cnt(err_cnt_o[1]), .done(done_o[1]),
    .state(state_o[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  function automatic bit ref_legal(logic [31:0] imm, logic src);
    longint s;
    s = longint'($signed(imm));
    if (src == 1'b0) return imm < 32'd4096;
    return (imm % 4 == 0) && (s >= -(64'sd1 <<< 25)) && (s <= (64'sd1 <<< 25) - 4);
  endfunction

  function automatic logic [31:0] ref_word(logic [19:0] hdr, logic [31:0] imm, logic src);
    logic [7:0] top;
    top = hdr[19:12];
    if (src == 1'b0) return (32'(hdr) << 12) + imm;
    return (32'(top) << 24) + ((imm >> 2) & 32'h00FF_FFFF);
  endfunction

  // The datapath's branch extend stage: sign-extend 24 bits and scale by 4.
  function automatic logic [31:0] sext_br(logic [31:0] w);
    return {{6{w[23]}}, w[23:0], 2'b00};
  endfunction

  function automatic logic [31:0] rand_imm(logic src, bit want_legal);
    int s;
    if (!want_legal) return $urandom;
    if (src == 1'b0) return 32'($urandom_range(0, 4095));
    s = int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
    return 32'(s * 4);
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the falling edge, advances the model over
  // the rising edge, and returns at the next falling edge with outputs stable.
  task automatic tick(input bit rst, input bit lb, input int ba, input bit v,
                      input logic [19:0] hdr, input logic [31:0] imm,
                      input bit src, input bit last);
    reset = rst; load_base = lb; base_addr = 2'(ba); in_valid = v;
    in_hdr = hdr; in_imm = imm; in_imm_src = src; in_last = last;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_ready[k]  = (m_st[k] == S_RUN) && !lb;
      seen_ready[k] = in_ready_o[k];
      exp_wr_en[k]  = 1'b0;
      exp_err[k]    = 1'b0;
      if (rst) begin
        m_st[k] = S_IDLE; m_addr[k] = 0; m_errs[k] = 0;
      end else if (lb) begin
        m_st[k] = S_RUN; m_addr[k] = ba;
      end else if (v && exp_ready[k]) begin
        if (ref_legal(imm, src)) begin
          exp_wr_en[k] = 1'b1;
          exp_addr[k]  = m_addr[k];
          exp_data[k]  = ref_word(hdr, imm, src);
          if (m_addr[k] == 3) begin
            m_addr[k] = 0;
            if (k == 0) m_st[k] = S_FULL;
          end else begin
            m_addr[k]++;
          end
        end else begin
          exp_err[k] = 1'b1;
          if (m_errs[k] < 255) m_errs[k]++;
        end
        if (last) m_st[k] = S_DONE;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, '0, '0, 0, 0);
    tick(1, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic load(input int ba);
    tick(0, 1, ba, 0, '0, '0, 0, 0);
  endtask

  task automatic beat(input logic [19:0] hdr, input logic [31:0] imm, input bit src, input bit last);
    tick(0, 0, 0, 1, hdr, imm, src, last);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({in_ready_o[k], wr_en_o[k], wr_addr_o[k], wr_data_o[k], err_o[k], err_cnt_o[k], done_o[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs u%0d: got rdy=%b wr=%b a=%h d=%h err=%b cnt=%0d done=%b want all 0",
                 k, in_ready_o[k], wr_en_o[k], wr_addr_o[k], wr_data_o[k], err_o[k], err_cnt_o[k], done_o[k]);
      end
      n_chk++;
      if (state_o[k] !== IDLE) begin
        n_fail++; $display("FAIL reset_state u%0d: got %0d want IDLE", k, state_o[k]);
      end
    end
  endtask

  task automatic test_dp_encode();
    do_reset();
    load(0);
    beat(20'hE3A01, 32'h0000_0005, 0, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0], err_o[0]} !== {1'b1, 2'd0, 32'hE3A0_1005, 1'b0}) begin
      n_fail++;
      $display("FAIL dp_encode: got wr=%b a=%0d d=%h err=%b want wr=1 a=0 d=e3a01005 err=0",
               wr_en_o[0], wr_addr_o[0], wr_data_o[0], err_o[0]);
    end
  endtask

  task automatic test_branch_encode();
    do_reset();
    load(0);
    beat(20'hEA000, 32'hFFFF_FFE8, 1, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0]} !== {1'b1, 2'd0, 32'hEAFF_FFFA}) begin
      n_fail++;
      $display("FAIL br_encode_neg: got wr=%b a=%0d d=%h want wr=1 a=0 d=eafffffa", wr_en_o[0], wr_addr_o[0], wr_data_o[0]);
    end
    n_chk++;
    if (sext_br(wr_data_o[0]) !== 32'hFFFF_FFE8) begin
      n_fail++; $display("FAIL br_roundtrip_neg: got %h want ffffffe8", sext_br(wr_data_o[0]));
    end
    beat(20'hEA000, 32'h01FF_FFFC, 1, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0]} !== {1'b1, 2'd1, 32'hEA7F_FFFF}) begin
      n_fail++;
      $display("FAIL br_encode_max: got wr=%b a=%0d d=%h want wr=1 a=1 d=ea7fffff", wr_en_o[0], wr_addr_o[0], wr_data_o[0]);
    end
    n_chk++;
    if (sext_br(wr_data_o[0]) !== 32'h01FF_FFFC) begin
      n_fail++; $display("FAIL br_roundtrip_max: got %h want 01fffffc", sext_br(wr_data_o[0]));
    end
  endtask

  task automatic test_rejects();
    logic [31:0] bad_imm [3];
    logic        bad_src [3];
    bad_imm[0] = 32'h0000_1000; bad_src[0] = 1'b0;
    bad_imm[1] = 32'h7FFF_FFFC; bad_src[1] = 1'b1;
    bad_imm[2] = 32'h0000_0006; bad_src[2] = 1'b1;
    do_reset();
    load(1);
    for (int i = 0; i < 3; i++) begin
      beat(20'h12345, bad_imm[i], bad_src[i], 0);
      n_chk++;
      if ({err_o[0], wr_en_o[0]} !== 2'b10) begin
        n_fail++; $display("FAIL reject_%0d: got err=%b wr=%b want err=1 wr=0", i, err_o[0], wr_en_o[0]);
      end
    end
    n_chk++;
    if (err_cnt_o[0] !== 8'd3) begin
      n_fail++; $display("FAIL reject_count: got %0d want 3", err_cnt_o[0]);
    end
    beat(20'h12345, 32'h0000_07FF, 0, 0);
    n_chk++;
    if ({wr_en_o[0], err_o[0], wr_addr_o[0], wr_data_o[0], err_cnt_o[0]} !== {1'b1, 1'b0, 2'd1, 32'h1234_57FF, 8'd3}) begin
      n_fail++;
      $display("FAIL reject_then_legal: got wr=%b err=%b a=%0d d=%h cnt=%0d want wr=1 err=0 a=1 d=123457ff cnt=3",
               wr_en_o[0], err_o[0], wr_addr_o[0], wr_data_o[0], err_cnt_o[0]);
    end
  endtask

  task automatic test_full_wrap();
    logic [31:0] imm;
    do_reset();
    load(0);
    for (int i = 0; i < 4; i++) begin
      imm = rand_imm(0, 1);
      beat(20'(i + 5), imm, 0, 0);
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if ({wr_en_o[k], wr_addr_o[k], wr_data_o[k]} !== {1'b1, 2'(i), ref_word(20'(i + 5), imm, 0)}) begin
          n_fail++;
          $display("FAIL fill_beat_%0d u%0d: got wr=%b a=%0d d=%h want wr=1 a=%0d d=%h",
                   i, k, wr_en_o[k], wr_addr_o[k], wr_data_o[k], i, ref_word(20'(i + 5), imm, 0));
        end
      end
    end
    n_chk++;
    if ({in_ready_o[0], state_o[0]} !== {1'b0, FULL}) begin
      n_fail++; $display("FAIL full_state: got rdy=%b st=%0d want rdy=0 st=FULL", in_ready_o[0], state_o[0]);
    end
    beat(20'hABCDE, 32'h0000_00AB, 0, 0);
    n_chk++;
    if (wr_en_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_hold: got wr=%b want 0", wr_en_o[0]);
    end
    n_chk++;
    if ({wr_en_o[1], wr_addr_o[1], wr_data_o[1]} !== {1'b1, 2'd0, 32'hABCD_E0AB}) begin
      n_fail++;
      $display("FAIL wrap_fifth: got wr=%b a=%0d d=%h want wr=1 a=0 d=abcde0ab", wr_en_o[1], wr_addr_o[1], wr_data_o[1]);
    end
    load(2);
    beat(20'hABCDE, 32'h0000_00AB, 0, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0]} !== {1'b1, 2'd2, 32'hABCD_E0AB}) begin
      n_fail++;
      $display("FAIL full_reload: got wr=%b a=%0d d=%h want wr=1 a=2 d=abcde0ab", wr_en_o[0], wr_addr_o[0], wr_data_o[0]);
    end
  endtask

  task automatic test_last_priority();
    do_reset();
    load(0);
    beat(20'h11111, 32'h0000_0001, 0, 0);
    beat(20'h22222, 32'h0000_0002, 0, 1);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], done_o[0], in_ready_o[0]} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL last_done: got wr=%b a=%0d done=%b rdy=%b want wr=1 a=1 done=1 rdy=0",
               wr_en_o[0], wr_addr_o[0], done_o[0], in_ready_o[0]);
    end
    beat(20'h33333, 32'h0000_0003, 0, 0);
    n_chk++;
    if ({wr_en_o[0], done_o[0], seen_ready[0]} !== {1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL done_holds: got wr=%b done=%b rdy=%b want wr=0 done=1 rdy=0", wr_en_o[0], done_o[0], seen_ready[0]);
    end
    tick(0, 1, 1, 1, 20'h44444, 32'h0000_0004, 0, 0);
    n_chk++;
    if ({wr_en_o[0], err_o[0]} !== 2'b00) begin
      n_fail++; $display("FAIL load_priority: got wr=%b err=%b want wr=0 err=0", wr_en_o[0], err_o[0]);
    end
    beat(20'h44444, 32'h0000_0004, 0, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0], done_o[0]} !== {1'b1, 2'd1, 32'h4444_4004, 1'b0}) begin
      n_fail++;
      $display("FAIL represent_beat: got wr=%b a=%0d d=%h done=%b want wr=1 a=1 d=44444004 done=0",
               wr_en_o[0], wr_addr_o[0], wr_data_o[0], done_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(0);
    tick(1, 0, 0, 1, 20'h55555, 32'h0000_0005, 0, 0);
    n_chk++;
    if ({wr_en_o[0], wr_data_o[0], in_ready_o[0], state_o[0]} !== {1'b0, 32'h0, 1'b0, IDLE}) begin
      n_fail++;
      $display("FAIL reset_with_beat: got wr=%b d=%h rdy=%b st=%0d want wr=0 d=0 rdy=0 st=IDLE",
               wr_en_o[0], wr_data_o[0], in_ready_o[0], state_o[0]);
    end
    load(0);
    beat(20'h66666, 32'h0000_0F00, 0, 0);
    beat(20'h77777, 32'h0000_1000, 0, 0);
    tick(1, 0, 0, 0, '0, '0, 0, 0);
    n_chk++;
    if ({wr_en_o[0], wr_addr_o[0], wr_data_o[0], err_o[0], err_cnt_o[0], state_o[0]} !== {1'b0, 2'd0, 32'h0, 1'b0, 8'd0, IDLE}) begin
      n_fail++;
      $display("FAIL reset_after_beats: got wr=%b a=%0d d=%h err=%b cnt=%0d st=%0d want all 0, IDLE",
               wr_en_o[0], wr_addr_o[0], wr_data_o[0], err_o[0], err_cnt_o[0], state_o[0]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    load(0);
    for (int i = 0; i < 257; i++) begin
      beat(20'(i), $urandom | 32'h0000_1000, 0, 0);
      n_chk++;
      if ({err_o[0], wr_en_o[0]} !== 2'b10) begin
        n_fail++; $display("FAIL sat_reject_%0d: got err=%b wr=%b want err=1 wr=0", i, err_o[0], wr_en_o[0]);
      end
    end
    n_chk++;
    if (err_cnt_o[0] !== 8'd255) begin
      n_fail++; $display("FAIL err_cnt_saturate: got %0d want 255", err_cnt_o[0]);
    end
  endtask

  task automatic test_random();
    int r;
    bit src, want_legal;
    logic [W-1:0] got;
    do_reset();
    load($urandom_range(0, 3));
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      src = 1'($urandom_range(0, 1));
      want_legal = ($urandom_range(0, 3) != 0);
      if (r < 2) tick(1, 0, 0, 0, '0, '0, 0, 0);
      else if (r < 7) tick(0, 1, $urandom_range(0, 3), 1, 20'($urandom), rand_imm(src, want_legal), src, 0);
      else tick(0, 0, 0, ($urandom_range(0, 4) != 0), 20'($urandom), rand_imm(src, want_legal), src,
                ($urandom_range(0, 29) == 0));
      if (exp_wr_en[0]) exp_q.push_back({2'(exp_addr[0]), exp_data[0]});
      if (wr_en_o[0]) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_write u0: got a=%0d d=%h want no write", wr_addr_o[0], wr_data_o[0]);
        end else begin
          got = exp_q.pop_front();
          if ({wr_addr_o[0], wr_data_o[0]} !== got) begin
            n_fail++; $display("FAIL rnd_write u0: got %h want %h", {wr_addr_o[0], wr_data_o[0]}, got);
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (seen_ready[k] !== exp_ready[k]) begin
          n_fail++; $display("FAIL rnd_in_ready u%0d cyc %0d: got %b want %b", k, c, seen_ready[k], exp_ready[k]);
        end
        n_chk++;
        if (wr_en_o[k] !== exp_wr_en[k]) begin
          n_fail++; $display("FAIL rnd_wr_en u%0d cyc %0d: got %b want %b", k, c, wr_en_o[k], exp_wr_en[k]);
        end
        if (k == 1 && exp_wr_en[k]) begin
          n_chk++;
          if ({wr_addr_o[k], wr_data_o[k]} !== {2'(exp_addr[k]), exp_data[k]}) begin
            n_fail++;
            $display("FAIL rnd_write u1 cyc %0d: got a=%0d d=%h want a=%0d d=%h", c, wr_addr_o[k], wr_data_o[k], exp_addr[k], exp_data[k]);
          end
        end
        n_chk++;
        if ({err_o[k], err_cnt_o[k], done_o[k]} !== {exp_err[k], 8'(m_errs[k]), (m_st[k] == S_DONE)}) begin
          n_fail++;
          $display("FAIL rnd_status u%0d cyc %0d: got err=%b cnt=%0d done=%b want err=%b cnt=%0d done=%b",
                   k, c, err_o[k], err_cnt_o[k], done_o[k], exp_err[k], m_errs[k], (m_st[k] == S_DONE));
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_missing_writes: got %0d left want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; load_base = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_hdr = '0; in_imm = '0; in_imm_src = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_IDLE; m_addr[k] = 0; m_errs[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_dp_encode();
    test_branch_encode();
    test_rejects();
    test_full_wrap();
    test_last_priority();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
